// File: rtl/ft245_sync_fifo_responder.sv
// Device-side FT245 synchronous FIFO model; Avalon-ST sink/source stand in for the USB host.
// Define FT245_RESPONDER_STALL_EN to add LFSR-driven random flag stalls.
module ft245_sync_fifo_responder #(
  parameter int DATA_WIDTH  = 8,
  parameter int BE_WIDTH    = 1,
  parameter int EMPTY_WIDTH = 1,
  parameter int RX_DEPTH    = 16,
  parameter int TX_DEPTH    = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  sink_data,
  input  logic [EMPTY_WIDTH-1:0] sink_empty,
  input  logic                   sink_valid,
  input  logic                   sink_startofpacket,
  input  logic                   sink_endofpacket,
  output logic                   sink_ready,
  output logic [DATA_WIDTH-1:0]  source_data,
  output logic [EMPTY_WIDTH-1:0] source_empty,
  output logic                   source_valid,
  output logic                   source_startofpacket,
  output logic                   source_endofpacket,
  input  logic                   source_ready,
  inout  wire  [DATA_WIDTH-1:0]  ft_data,
  inout  wire  [BE_WIDTH-1:0]    ft_be,
  output logic                   ft_txe_n,
  output logic                   ft_rxf_n,
  input  logic                   ft_oe_n,
  input  logic                   ft_rd_n,
  input  logic                   ft_wr_n,
  output logic                   protocol_error
);
  localparam int RX_AW  = $clog2(RX_DEPTH);
  localparam int TX_AW  = $clog2(TX_DEPTH);
  localparam int WORD_W = DATA_WIDTH + BE_WIDTH;
  localparam logic [TX_AW:0] TX_FULL = (TX_AW+1)'(TX_DEPTH);

  logic [WORD_W-1:0]   rx_mem [RX_DEPTH];
  logic [WORD_W-1:0]   tx_mem [TX_DEPTH];
  logic [RX_AW:0]      rx_wr_ptr, rx_rd_ptr, rx_count, rx_count_next;
  logic [TX_AW:0]      tx_wr_ptr, tx_rd_ptr, tx_count, tx_count_next;
  logic                rx_full, tx_empty, ready_en;
  logic                rx_push, rx_pop, tx_push, tx_pop, stall, violation;
  logic [BE_WIDTH-1:0] sink_be, tx_be;
  logic [WORD_W-1:0]   rx_head, tx_head;
  logic                unused_sop;
  int                  be_ones;

  assign unused_sop = sink_startofpacket;

  // Pointers carry one extra bit: equal low bits with differing MSB means full.
  assign rx_full  = (rx_wr_ptr[RX_AW] != rx_rd_ptr[RX_AW]) &&
                    (rx_wr_ptr[RX_AW-1:0] == rx_rd_ptr[RX_AW-1:0]);
  assign tx_empty = (tx_wr_ptr == tx_rd_ptr);
  assign rx_count = rx_wr_ptr - rx_rd_ptr;
  assign tx_count = tx_wr_ptr - tx_rd_ptr;

  assign sink_ready   = ready_en & ~rx_full;
  assign source_valid = ~tx_empty;
  assign rx_push = sink_valid & sink_ready;
  assign rx_pop  = ~ft_rd_n & ~ft_oe_n & ~ft_rxf_n;
  assign tx_push = ~ft_wr_n & ~ft_txe_n;
  assign tx_pop  = source_valid & source_ready;

  assign rx_count_next = rx_count + (RX_AW+1)'(rx_push) - (RX_AW+1)'(rx_pop);
  assign tx_count_next = tx_count + (TX_AW+1)'(tx_push) - (TX_AW+1)'(tx_pop);

  assign violation = (~ft_wr_n & ft_txe_n) | (~ft_rd_n & ft_rxf_n) |
                     (~ft_rd_n & ft_oe_n) | (~ft_oe_n & ~ft_wr_n);

  assign sink_be = sink_endofpacket ? ({BE_WIDTH{1'b1}} >> sink_empty) : {BE_WIDTH{1'b1}};

`ifdef FT245_RESPONDER_STALL_EN
  logic [15:0] lfsr, lfsr_next;
  assign lfsr_next = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) lfsr <= 16'hACE1;
    else       lfsr <= lfsr_next;
  end
  // Flags are registered alongside the LFSR value they will be shown with.
  assign stall = (lfsr_next[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_wr_ptr      <= '0;
      rx_rd_ptr      <= '0;
      tx_wr_ptr      <= '0;
      tx_rd_ptr      <= '0;
      ready_en       <= 1'b0;
      ft_txe_n       <= 1'b1;
      ft_rxf_n       <= 1'b1;
      protocol_error <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (rx_push) rx_wr_ptr <= rx_wr_ptr + (RX_AW+1)'(1);
      if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + (RX_AW+1)'(1);
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + (TX_AW+1)'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + (TX_AW+1)'(1);
      ft_txe_n <= (tx_count_next == TX_FULL) | stall;
      // Falls only once the FIFO was already non-empty; rises on the emptying pop.
      ft_rxf_n <= (rx_count_next == '0) | (rx_count == '0) | stall;
      protocol_error <= protocol_error | violation;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr[RX_AW-1:0]] <= {sink_be, sink_data};
    if (tx_push) tx_mem[tx_wr_ptr[TX_AW-1:0]] <= {ft_be, ft_data};
  end

  assign rx_head = rx_mem[rx_rd_ptr[RX_AW-1:0]];
  assign tx_head = tx_mem[tx_rd_ptr[TX_AW-1:0]];

  assign ft_data = (!ft_oe_n && !reset) ? rx_head[DATA_WIDTH-1:0] : {DATA_WIDTH{1'bz}};
  assign ft_be   = (!ft_oe_n && !reset) ? rx_head[WORD_W-1:DATA_WIDTH] : {BE_WIDTH{1'bz}};

  assign source_data          = tx_head[DATA_WIDTH-1:0];
  assign tx_be                = tx_head[WORD_W-1:DATA_WIDTH];
  assign source_startofpacket = source_valid;
  assign source_endofpacket   = source_valid;

  always_comb begin
    be_ones = 0;
    for (int i = 0; i < BE_WIDTH; i++) be_ones = be_ones + int'(tx_be[i]);
    source_empty = (be_ones >= BE_WIDTH) ? '0 : EMPTY_WIDTH'(BE_WIDTH - be_ones);
  end
endmodule

// File: tb/tb_ft245_sync_fifo_responder.sv
// Self-checking bench for ft245_sync_fifo_responder (32-bit data, depth 16), directed plus random loopback.
// With FT245_RESPONDER_STALL_EN defined only the reset and loopback scenarios run.
module tb_ft245_sync_fifo_responder;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] sink_data = '0;
  logic [1:0]  sink_empty = '0;
  logic        sink_valid = 1'b0, sink_startofpacket = 1'b0, sink_endofpacket = 1'b0;
  logic        sink_ready;
  logic [31:0] source_data;
  logic [1:0]  source_empty;
  logic        source_valid, source_startofpacket, source_endofpacket;
  logic        source_ready = 1'b0;
  wire  [31:0] ft_data;
  wire  [3:0]  ft_be;
  logic        ft_txe_n, ft_rxf_n, protocol_error;
  logic        ft_oe_n = 1'b1, ft_rd_n = 1'b1, ft_wr_n = 1'b1;
  logic        tb_drv = 1'b0;
  logic [31:0] tb_data = '0;
  logic [3:0]  tb_be = '0;

  int errors = 0;
  int checks = 0;

  logic [31:0] w_data  [200];
  logic [1:0]  w_empty [200];
  logic        w_eop   [200];

  assign ft_data = tb_drv ? tb_data : 32'bz;
  assign ft_be   = tb_drv ? tb_be : 4'bz;

  always #5 clk = ~clk;

  ft245_sync_fifo_responder #(
    .DATA_WIDTH(32), .BE_WIDTH(4), .EMPTY_WIDTH(2), .RX_DEPTH(16), .TX_DEPTH(16)
  ) dut (
    .clk(clk), .reset(reset),
    .sink_data(sink_data), .sink_empty(sink_empty), .sink_valid(sink_valid),
    .sink_startofpacket(sink_startofpacket), .sink_endofpacket(sink_endofpacket),
    .sink_ready(sink_ready),
    .source_data(source_data), .source_empty(source_empty), .source_valid(source_valid),
    .source_startofpacket(source_startofpacket), .source_endofpacket(source_endofpacket),
    .source_ready(source_ready),
    .ft_data(ft_data), .ft_be(ft_be), .ft_txe_n(ft_txe_n), .ft_rxf_n(ft_rxf_n),
    .ft_oe_n(ft_oe_n), .ft_rd_n(ft_rd_n), .ft_wr_n(ft_wr_n),
    .protocol_error(protocol_error)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sink_valid = 1'b0; sink_startofpacket = 1'b0; sink_endofpacket = 1'b0; sink_empty = '0;
    source_ready = 1'b0;
    ft_oe_n = 1'b1; ft_rd_n = 1'b1; ft_wr_n = 1'b1; tb_drv = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    #3;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ft_txe_n !== 1'b1) begin errors++; $display("FAIL rst_txe_n: got %0b expected 1", ft_txe_n); end
    checks++; if (ft_rxf_n !== 1'b1) begin errors++; $display("FAIL rst_rxf_n: got %0b expected 1", ft_rxf_n); end
    checks++; if (sink_ready !== 1'b0) begin errors++; $display("FAIL rst_sink_ready: got %0b expected 0", sink_ready); end
    checks++; if (source_valid !== 1'b0) begin errors++; $display("FAIL rst_source_valid: got %0b expected 0", source_valid); end
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL rst_perr: got %0b expected 0", protocol_error); end
    reset = 1'b0;
    tick();
    checks++; if (ft_txe_n !== 1'b0) begin errors++; $display("FAIL post_rst_txe_n: got %0b expected 0", ft_txe_n); end
    checks++; if (sink_ready !== 1'b1) begin errors++; $display("FAIL post_rst_sink_ready: got %0b expected 1", sink_ready); end
    checks++; if (ft_rxf_n !== 1'b1) begin errors++; $display("FAIL post_rst_rxf_n: got %0b expected 1", ft_rxf_n); end
  endtask

  task automatic test_rx_basic();
    sink_valid = 1'b1; sink_data = 32'h11;
    tick();
    checks++; if (ft_rxf_n !== 1'b1) begin errors++; $display("FAIL rxf_wait: got %0b expected 1", ft_rxf_n); end
    sink_data = 32'h22;
    tick();
    checks++; if (ft_rxf_n !== 1'b0) begin errors++; $display("FAIL rxf_fall: got %0b expected 0", ft_rxf_n); end
    sink_data = 32'h33;
    tick();
    sink_valid = 1'b0;
    ft_oe_n = 1'b0; ft_rd_n = 1'b0;
    #1;
    checks++; if (ft_data !== 32'h11) begin errors++; $display("FAIL rd_word0: got %0h expected 11", ft_data); end
    tick();
    checks++; if (ft_data !== 32'h22) begin errors++; $display("FAIL rd_word1: got %0h expected 22", ft_data); end
    tick();
    checks++; if (ft_data !== 32'h33) begin errors++; $display("FAIL rd_word2: got %0h expected 33", ft_data); end
    checks++; if (ft_rxf_n !== 1'b0) begin errors++; $display("FAIL rxf_before_last: got %0b expected 0", ft_rxf_n); end
    tick();
    ft_oe_n = 1'b1; ft_rd_n = 1'b1;
    checks++; if (ft_rxf_n !== 1'b1) begin errors++; $display("FAIL rxf_rise: got %0b expected 1", ft_rxf_n); end
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL rx_basic_perr: got %0b expected 0", protocol_error); end
  endtask

  task automatic test_tx_fill();
    source_ready = 1'b0; tb_drv = 1'b1; tb_be = 4'hF;
    for (int i = 0; i < 16; i++) begin
      checks++; if (ft_txe_n !== 1'b0) begin errors++; $display("FAIL fill_txe_n[%0d]: got %0b expected 0", i, ft_txe_n); end
      tb_data = 32'(i); ft_wr_n = 1'b0;
      tick();
    end
    checks++; if (ft_txe_n !== 1'b1) begin errors++; $display("FAIL full_txe_n: got %0b expected 1", ft_txe_n); end
    tb_data = 32'hEE;
    tick();
    ft_wr_n = 1'b1; tb_drv = 1'b0;
    checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL write_when_full_perr: got %0b expected 1", protocol_error); end
    source_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++; if (source_valid !== 1'b1 || source_data !== 32'(i)) begin
        errors++; $display("FAIL drain[%0d]: got valid=%0b data=%0h expected valid=1 data=%0h", i, source_valid, source_data, i);
      end
      tick();
    end
    source_ready = 1'b0;
    checks++; if (source_valid !== 1'b0) begin errors++; $display("FAIL no_17th_word: got valid=%0b expected 0", source_valid); end
    checks++; if (ft_txe_n !== 1'b0) begin errors++; $display("FAIL drained_txe_n: got %0b expected 0", ft_txe_n); end
  endtask

  task automatic test_byte_enable();
    sink_valid = 1'b1; sink_data = 32'hAABBCCDD; sink_startofpacket = 1'b1;
    sink_endofpacket = 1'b1; sink_empty = 2'd1;
    tick();
    idle();
    tick();
    checks++; if (ft_rxf_n !== 1'b0) begin errors++; $display("FAIL be_rxf_n: got %0b expected 0", ft_rxf_n); end
    ft_oe_n = 1'b0;
    #1;
    checks++; if (ft_be !== 4'b0111) begin errors++; $display("FAIL rd_be: got %0b expected 0111", ft_be); end
    checks++; if (ft_data !== 32'hAABBCCDD) begin errors++; $display("FAIL rd_be_data: got %0h expected aabbccdd", ft_data); end
    ft_rd_n = 1'b0;
    tick();
    ft_rd_n = 1'b1; ft_oe_n = 1'b1;
    tb_drv = 1'b1; tb_data = 32'h12345678; tb_be = 4'b0011; ft_wr_n = 1'b0;
    tick();
    ft_wr_n = 1'b1; tb_drv = 1'b0;
    checks++; if (source_valid !== 1'b1 || source_empty !== 2'd2) begin
      errors++; $display("FAIL source_empty: got valid=%0b empty=%0d expected valid=1 empty=2", source_valid, source_empty);
    end
    checks++; if (source_startofpacket !== 1'b1 || source_endofpacket !== 1'b1 || source_data !== 32'h12345678) begin
      errors++; $display("FAIL source_word: got sop=%0b eop=%0b data=%0h expected 1 1 12345678",
                         source_startofpacket, source_endofpacket, source_data);
    end
    source_ready = 1'b1;
    tick();
    source_ready = 1'b0;
    checks++; if (source_valid !== 1'b0) begin errors++; $display("FAIL be_pop: got valid=%0b expected 0", source_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q[$];
    int n;
    tb_drv = 1'b1; tb_be = 4'hF;
    for (int i = 0; i < 15; i++) begin
      tb_data = 32'h100 + 32'(i); ft_wr_n = 1'b0; q.push_back(tb_data);
      tick();
    end
    checks++; if (ft_txe_n !== 1'b0) begin errors++; $display("FAIL b2b_15_txe_n: got %0b expected 0", ft_txe_n); end
    tb_data = 32'h10F; source_ready = 1'b1;
    tick();
    q.push_back(32'h10F); void'(q.pop_front());
    checks++; if (ft_txe_n !== 1'b0) begin errors++; $display("FAIL b2b_count_held: got %0b expected 0", ft_txe_n); end
    source_ready = 1'b0; tb_data = 32'h110;
    tick();
    q.push_back(32'h110);
    checks++; if (ft_txe_n !== 1'b1) begin errors++; $display("FAIL b2b_full: got %0b expected 1", ft_txe_n); end
    tb_data = 32'hBAD; source_ready = 1'b1;
    tick();
    void'(q.pop_front());
    ft_wr_n = 1'b1; tb_drv = 1'b0; source_ready = 1'b0;
    checks++; if (ft_txe_n !== 1'b0) begin errors++; $display("FAIL b2b_full_pop_txe_n: got %0b expected 0", ft_txe_n); end
    checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL b2b_perr: got %0b expected 1", protocol_error); end
    source_ready = 1'b1;
    n = q.size();
    for (int i = 0; i < n; i++) begin
      checks++; if (source_valid !== 1'b1 || source_data !== q[i]) begin
        errors++; $display("FAIL b2b_drain[%0d]: got valid=%0b data=%0h expected valid=1 data=%0h", i, source_valid, source_data, q[i]);
      end
      tick();
    end
    source_ready = 1'b0;
    checks++; if (source_valid !== 1'b0) begin errors++; $display("FAIL b2b_no_extra: got valid=%0b expected 0", source_valid); end
  endtask

  task automatic test_protocol_error();
    ft_oe_n = 1'b0; ft_rd_n = 1'b0;
    tick();
    idle();
    checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL rd_when_empty_perr: got %0b expected 1", protocol_error); end
    do_reset();
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL perr_cleared: got %0b expected 0", protocol_error); end
    ft_oe_n = 1'b0; ft_wr_n = 1'b0;
    tick();
    idle();
    checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL contention_perr: got %0b expected 1", protocol_error); end
    repeat (5) tick();
    checks++; if (protocol_error !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %0b expected 1", protocol_error); end
    sink_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      sink_data = 32'hC0 + 32'(k);
      tick();
    end
    sink_valid = 1'b0;
    tick();
    ft_oe_n = 1'b0; ft_rd_n = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++; if (ft_rxf_n !== 1'b1 || ft_txe_n !== 1'b1) begin
      errors++; $display("FAIL midburst_flags: got rxf_n=%0b txe_n=%0b expected 1 1", ft_rxf_n, ft_txe_n);
    end
    checks++; if (source_valid !== 1'b0 || sink_ready !== 1'b0) begin
      errors++; $display("FAIL midburst_valid: got source_valid=%0b sink_ready=%0b expected 0 0", source_valid, sink_ready);
    end
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL midburst_perr: got %0b expected 0", protocol_error); end
    idle();
    #3;
    reset = 1'b0;
    tick();
    tick();
    checks++; if (ft_rxf_n !== 1'b1 || source_valid !== 1'b0 || ft_txe_n !== 1'b0) begin
      errors++; $display("FAIL after_midburst: got rxf_n=%0b source_valid=%0b txe_n=%0b expected 1 0 0", ft_rxf_n, source_valid, ft_txe_n);
    end
  endtask

  task automatic test_loopback();
    int in_idx = 0, rd_idx = 0, out_idx = 0, tx_in = 0, cyc = 0;
    int rx_occ, tx_occ, rx_occ_prev = 0;
    int stall_tx = 0, stall_rx = 0;
    logic [35:0] bq[$];
    logic [3:0]  exp_be;
    logic [1:0]  exp_empty;
    for (int i = 0; i < 200; i++) begin
      w_data[i]  = $urandom;
      w_eop[i]   = ($urandom_range(3) == 0);
      w_empty[i] = 2'($urandom_range(3));
    end
    idle();
    while (out_idx < 200 && cyc < 20000) begin
      tick();
      cyc++;
      rx_occ = in_idx - rd_idx;
      tx_occ = tx_in - out_idx;
`ifdef FT245_RESPONDER_STALL_EN
      if (ft_txe_n && tx_occ < 16) stall_tx++;
      if (ft_rxf_n && rx_occ >= 2) stall_rx++;
      checks++; if (!ft_txe_n && tx_occ >= 16) begin errors++; $display("FAIL lb_txe_n_full: got 0 expected 1 (occ=%0d)", tx_occ); end
      checks++; if (!ft_rxf_n && rx_occ == 0) begin errors++; $display("FAIL lb_rxf_n_empty: got 0 expected 1"); end
`else
      checks++; if (ft_txe_n !== (tx_occ == 16)) begin
        errors++; $display("FAIL lb_txe_n: got %0b expected %0b (occ=%0d)", ft_txe_n, (tx_occ == 16), tx_occ);
      end
      checks++; if (ft_rxf_n !== (rx_occ == 0 || rx_occ_prev == 0)) begin
        errors++; $display("FAIL lb_rxf_n: got %0b expected %0b (occ=%0d prev=%0d)", ft_rxf_n, (rx_occ == 0 || rx_occ_prev == 0), rx_occ, rx_occ_prev);
      end
`endif
      rx_occ_prev = rx_occ;
      checks++; if (sink_ready !== (rx_occ != 16)) begin errors++; $display("FAIL lb_sink_ready: got %0b expected %0b", sink_ready, (rx_occ != 16)); end
      checks++; if (source_valid !== (tx_occ != 0)) begin errors++; $display("FAIL lb_source_valid: got %0b expected %0b", source_valid, (tx_occ != 0)); end

      if (in_idx < 200 && $urandom_range(3) != 0) begin
        sink_valid = 1'b1; sink_data = w_data[in_idx];
        sink_endofpacket = w_eop[in_idx]; sink_startofpacket = w_eop[in_idx]; sink_empty = w_empty[in_idx];
      end else begin
        sink_valid = 1'b0;
      end
      if (sink_valid && sink_ready) in_idx++;

      source_ready = 1'($urandom_range(1));
      if (source_valid && source_ready && out_idx < 200) begin
        exp_empty = w_eop[out_idx] ? w_empty[out_idx] : 2'd0;
        checks++; if (source_data !== w_data[out_idx] || source_empty !== exp_empty) begin
          errors++; $display("FAIL lb_source[%0d]: got data=%0h empty=%0d expected data=%0h empty=%0d",
                             out_idx, source_data, source_empty, w_data[out_idx], exp_empty);
        end
        out_idx++;
      end

      ft_oe_n = 1'b1; ft_rd_n = 1'b1; ft_wr_n = 1'b1; tb_drv = 1'b0;
      if (!ft_rxf_n && rd_idx < 200 && bq.size() < 4 && $urandom_range(1) == 1) begin
        ft_oe_n = 1'b0; ft_rd_n = 1'b0;
        #1;
        exp_be = w_eop[rd_idx] ? (4'hF >> w_empty[rd_idx]) : 4'hF;
        checks++; if (ft_data !== w_data[rd_idx] || ft_be !== exp_be) begin
          errors++; $display("FAIL lb_ft_read[%0d]: got data=%0h be=%0b expected data=%0h be=%0b",
                             rd_idx, ft_data, ft_be, w_data[rd_idx], exp_be);
        end
        bq.push_back({ft_be, ft_data});
        rd_idx++;
      end else if (bq.size() > 0 && !ft_txe_n) begin
        tb_drv = 1'b1;
        {tb_be, tb_data} = bq.pop_front();
        ft_wr_n = 1'b0;
        tx_in++;
      end
    end
    idle();
    checks++; if (out_idx != 200) begin errors++; $display("FAIL lb_count: got %0d words expected 200 within cycle budget", out_idx); end
    checks++; if (protocol_error !== 1'b0) begin errors++; $display("FAIL lb_perr: got %0b expected 0", protocol_error); end
`ifdef FT245_RESPONDER_STALL_EN
    checks++; if (stall_tx == 0) begin errors++; $display("FAIL lb_stall_tx: got 0 stalled cycles expected >0"); end
    checks++; if (stall_rx == 0) begin errors++; $display("FAIL lb_stall_rx: got 0 stalled cycles expected >0"); end
`endif
  endtask

  initial begin
    test_reset();
`ifndef FT245_RESPONDER_STALL_EN
    test_rx_basic();
    do_reset();
    test_tx_fill();
    do_reset();
    test_byte_enable();
    do_reset();
    test_back_to_back();
    do_reset();
    test_protocol_error();
`endif
    do_reset();
    test_loopback();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached, expected completion before it");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "time limit");
  end
endmodule
